// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/response bus between the two requesters (M, D),
// the arbiter and the single-port memory.
// slave  : arbiter side (takes requests and mem_rd, drives done/rd and memory controls)
// master : requester/memory side (the opposite directions)
interface mem_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             m_req;
    logic             m_we;
    logic [WIDTH-1:0] m_adr;
    logic [WIDTH-1:0] m_wd;
    logic             m_done;
    logic [WIDTH-1:0] m_rd;

    logic             d_req;
    logic             d_we;
    logic [WIDTH-1:0] d_adr;
    logic [WIDTH-1:0] d_wd;
    logic             d_lock;
    logic             d_done;
    logic [WIDTH-1:0] d_rd;

    logic             mem_we;
    logic [WIDTH-1:0] mem_adr;
    logic [WIDTH-1:0] mem_wd;
    logic [WIDTH-1:0] mem_rd;

    modport slave (
        input  m_req, m_we, m_adr, m_wd,
        input  d_req, d_we, d_adr, d_wd, d_lock,
        input  mem_rd,
        output m_done, m_rd, d_done, d_rd,
        output mem_we, mem_adr, mem_wd
    );

    modport master (
        output m_req, m_we, m_adr, m_wd,
        output d_req, d_we, d_adr, d_wd, d_lock,
        output mem_rd,
        input  m_done, m_rd, d_done, d_rd,
        input  mem_we, mem_adr, mem_wd
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the MIPS core (M) and a
// debug/loader DMA engine (D). Round-robin grant, optional D-side lock bounded
// by MAXLOCK while M waits, one access per two cycles back to back.
// Optional build macro MEM_ARB_STATS_EN adds per-port completion counters and a
// starvation-override pulse.
//
// state | meaning
// IDLE  | no owner, memory controls parked at 0
// ACC   | owner's request fields drive the memory; read data captured at exit
// DONE  | owner's done pulse, x_rd valid; next grant decided here
module mem_arbiter #(
    parameter int WIDTH   = 8,
    parameter int MAXLOCK = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [7:0]    m_cnt,
    output logic [7:0]    d_cnt,
    output logic          starve_evt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic       OWN_M    = 1'b0;
    localparam logic       OWN_D    = 1'b1;
    localparam logic [3:0] LOCK_MAX = 4'(MAXLOCK);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_owner;
    logic             w_owner_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic [3:0]       r_lockcnt;
    logic [3:0]       w_lockcnt_nxt;
    logic [WIDTH-1:0] r_m_rd;
    logic [WIDTH-1:0] r_d_rd;

    logic             w_lock_keep;
    logic             w_override;
    logic             w_own_we;
    logic [WIDTH-1:0] w_own_adr;
    logic [WIDTH-1:0] w_own_wd;

    // D asks to stay owner; only meaningful at the end of one of its accesses
    assign w_lock_keep = (r_state == DONE) && (r_owner == OWN_D) && bus.d_lock && bus.d_req;
    // M has waited through MAXLOCK locked D accesses: break the lock
    assign w_override  = w_lock_keep && bus.m_req && (r_lockcnt >= LOCK_MAX);

    // Owner's request fields, muxed once for the memory bus and read capture
    always_comb begin
        w_own_we  = bus.m_we;
        w_own_adr = bus.m_adr;
        w_own_wd  = bus.m_wd;
        if (r_owner == OWN_D) begin
            w_own_we  = bus.d_we;
            w_own_adr = bus.d_adr;
            w_own_wd  = bus.d_wd;
        end
    end

    // State, owner, round-robin pointer and lock counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_owner   <= OWN_M;
            r_last    <= OWN_D;
            r_lockcnt <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_last    <= w_last_nxt;
            r_lockcnt <= w_lockcnt_nxt;
        end
    end

    // Next-state and arbitration: grants are only decided in IDLE and DONE
    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_last_nxt    = r_last;
        w_lockcnt_nxt = r_lockcnt;
        case (r_state)
            IDLE, DONE: begin
                if (w_lock_keep && !w_override) begin
                    w_state_nxt   = ACC;
                    w_owner_nxt   = OWN_D;
                    w_last_nxt    = OWN_D;
                    w_lockcnt_nxt = (r_lockcnt == 4'hF) ? 4'hF : r_lockcnt + 4'd1;
                end else if (w_override) begin
                    w_state_nxt   = ACC;
                    w_owner_nxt   = OWN_M;
                    w_last_nxt    = OWN_M;
                    w_lockcnt_nxt = 4'd0;
                end else if (bus.m_req && bus.d_req) begin
                    // tie: the side that did not win last time goes now
                    w_state_nxt   = ACC;
                    w_owner_nxt   = ~r_last;
                    w_last_nxt    = ~r_last;
                    w_lockcnt_nxt = 4'd0;
                end else if (bus.m_req) begin
                    w_state_nxt   = ACC;
                    w_owner_nxt   = OWN_M;
                    w_last_nxt    = OWN_M;
                    w_lockcnt_nxt = 4'd0;
                end else if (bus.d_req) begin
                    w_state_nxt   = ACC;
                    w_owner_nxt   = OWN_D;
                    w_last_nxt    = OWN_D;
                    w_lockcnt_nxt = 4'd0;
                end else begin
                    w_state_nxt   = IDLE;
                    w_lockcnt_nxt = 4'd0;
                end
            end
            ACC: begin
                w_state_nxt = DONE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Memory bus is driven only during ACC; write enable can never leak out
    always_comb begin
        bus.mem_we  = 1'b0;
        bus.mem_adr = '0;
        bus.mem_wd  = '0;
        if (r_state == ACC) begin
            bus.mem_we  = w_own_we;
            bus.mem_adr = w_own_adr;
            bus.mem_wd  = w_own_wd;
        end
    end

    // Capture read data leaving ACC so x_rd is valid alongside the done pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m_rd <= '0;
            r_d_rd <= '0;
        end else if ((r_state == ACC) && !w_own_we) begin
            if (r_owner == OWN_M) begin
                r_m_rd <= bus.mem_rd;
            end else begin
                r_d_rd <= bus.mem_rd;
            end
        end
    end

    assign bus.m_done = (r_state == DONE) && (r_owner == OWN_M);
    assign bus.d_done = (r_state == DONE) && (r_owner == OWN_D);
    assign bus.m_rd   = r_m_rd;
    assign bus.d_rd   = r_d_rd;

`ifdef MEM_ARB_STATS_EN
    logic [7:0] r_m_cnt;
    logic [7:0] r_d_cnt;

    // Saturating per-port completion counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m_cnt <= 8'd0;
            r_d_cnt <= 8'd0;
        end else begin
            if (bus.m_done && (r_m_cnt != 8'hFF)) begin
                r_m_cnt <= r_m_cnt + 8'd1;
            end
            if (bus.d_done && (r_d_cnt != 8'hFF)) begin
                r_d_cnt <= r_d_cnt + 8'd1;
            end
        end
    end

    assign m_cnt      = r_m_cnt;
    assign d_cnt      = r_d_cnt;
    assign starve_evt = w_override;
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port 8-bit memory in mips_mem between two requesters: the MIPS core (port M) and a debug/loader DMA engine (port D).
- Sits between the core's adr/writedata/memwrite bus and the memory array.
- Grants one access at a time using round-robin with an optional D-side lock and a starvation limit.
- Returns read data with a one-cycle done pulse.

Parameters:
- WIDTH, 8: data and address width in bits.
- MAXLOCK, 4: maximum consecutive locked D accesses while M is requesting; range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- m_req  input  1  M access request; held high until m_done.
- m_we  input  1  M write enable; 1 = write, 0 = read.
- m_adr  input  WIDTH  M address.
- m_wd  input  WIDTH  M write data.
- m_done  output  1  one-cycle pulse: M access complete.
- m_rd  output  WIDTH  M read data; valid while m_done is high, held until the next M done.
- d_req, d_we, d_adr, d_wd  input  1/1/WIDTH/WIDTH  D request fields; same rules as M.
- d_lock  input  1  D asks to keep ownership for its next access.
- d_done  output  1  one-cycle pulse: D access complete.
- d_rd  output  WIDTH  D read data; same rules as m_rd.
- mem_we  output  1  memory write enable.
- mem_adr  output  WIDTH  memory address.
- mem_wd  output  WIDTH  memory write data.
- mem_rd  input  WIDTH  memory read data; valid one cycle after mem_adr is presented.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, owner=M, last=D (so M wins the first tie), lockcnt=0.
  - All outputs are 0, including m_rd and d_rd.
- States:
  - IDLE: no owner; mem_we=0, mem_adr=0, mem_wd=0.
  - ACC: mem_adr, mem_wd and mem_we are driven combinationally from the owner's request fields. mem_we equals the owner's we and is asserted only in ACC.
  - DONE: owner_rd <= mem_rd (registered); owner_done=1 for exactly this cycle; mem_we=0.
- Arbitration (evaluated in IDLE and in DONE):
  - Only one requester active: that requester wins.
  - Both active: the requester that is not `last` wins, then last <= winner.
  - No requester active: go to IDLE.
- Lock rule, applied in DONE:
  - If owner=D, d_lock=1 and d_req=1, D keeps ownership and lockcnt increments.
  - If m_req=1 and lockcnt reaches MAXLOCK, the lock is overridden and M wins.
  - lockcnt clears whenever M is granted or D's lock ends.
- Latency:
  - A request seen in IDLE at cycle 0 is in ACC at cycle 1 and DONE at cycle 2.
  - Back-to-back throughput is 1 access per 2 cycles (DONE goes straight to ACC).
- Request fields:
  - Requesters must hold req, we, adr and wd stable from assertion until done.
  - The arbiter samples req only in IDLE or DONE.
  - A requester that drops req at its done cycle is not re-granted.
- Write accesses still produce a done pulse; x_rd is left unchanged on a write.
- Dropping req while in ACC is illegal; the access still completes.
- Reset asserted mid-ACC: mem_we drops immediately and no done pulse is issued.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined:
  - Adds outputs m_cnt and d_cnt, each 8 bits, counting completed accesses per port.
  - Counters saturate at 8'hFF and clear on reset.
  - Adds output starve_evt: a one-cycle pulse when the MAXLOCK override fires.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Single M read: mem preloaded [8'h10]=8'h0D; m_req=1, m_we=0, m_adr=8'h10 -> mem_adr=8'h10 at cycle 1; m_done=1 with m_rd=8'h0D at cycle 2.
- Simultaneous requests after reset: M and D request in the same cycle -> M granted first, then D; alternation continues while both hold req.
- Write path: d_req, d_we=1, d_adr=8'hFF, d_wd=8'h0D -> mem_we=1 exactly one cycle with mem_adr=8'hFF, mem_wd=8'h0D; d_done pulses the next cycle; d_rd unchanged.
- Lock plus starvation, MAXLOCK=4: D locks while m_req=1 -> D completes 5 accesses (first grant plus 4 locked), then M is granted; starve_evt pulses once when the stats macro is defined.
- Reset during ACC: reset low mid-access -> all outputs are 0 immediately; no done pulse; after release, arbitration restarts with M preferred.
- Idle: no requests for 10 cycles -> mem_we=0, mem_adr=0, no done pulses.
